// File: rtl/alu_csr_bank.sv
// alu_csr_bank: byte-serial CSR bank for the ALU subsystem.
// Holds the CTRL register (k_val/c_val) and NUM_CH sum-of-results
// accumulators with read-clear, reached over a header+data context bus.
// Optional macro ALU_CSR_SAT_EN: accumulators saturate at all-ones
// instead of wrapping.
//
// Context bus: a byte is transferred on every cycle ctx_val is high; there
// is no back-pressure. Read data comes back on ctx_out, one byte per cycle,
// flagged by ctx_out_val; ctx_out is held at zero when ctx_out_val is low.
module alu_csr_bank #(
    parameter int DATA_W = 32,
    parameter int NUM_CH = 4,
    localparam int BYTES = DATA_W / 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ctx_val,
    input  logic [7:0]               ctx_in,
    input  logic [NUM_CH-1:0]        alu_ready,
    input  logic [NUM_CH*DATA_W-1:0] alu_result,
    output logic [7:0]               ctx_out,
    output logic                     ctx_out_val,
    output logic [7:0]               k_val,
    output logic [7:0]               c_val,
    output logic                     busy
);
    localparam int CW = $clog2(BYTES + 1);
    localparam logic [6:0]  CTRL_ADDR = 7'h20;
    localparam logic [31:0] FILL      = 32'hDEADBEEF;

    typedef enum logic [2:0] {IDLE, WR_DATA, WR_COMMIT, RD_DELAY, RD_DATA} state_t;

    state_t                     state;
    state_t                     state_nxt;
    logic                       ctx_val_r;
    logic [7:0]                 ctx_in_r;
    logic [6:0]                 addr;
    logic [CW-1:0]              cnt;
    logic                       last_byte;
    logic [DATA_W-1:0]          wr_word;
    logic [DATA_W-1:0]          rd_shift;
    logic [DATA_W-1:0]          rd_word;
    logic [7:0]                 ctx_out_r;
    logic                       ctx_out_val_r;
    logic [15:0]                ctrl;
    logic [NUM_CH*DATA_W-1:0]   sor_flat;

    assign last_byte = (cnt == CW'(BYTES - 1));
    assign k_val     = ctrl[7:0];
    assign c_val     = ctrl[15:8];
    assign busy      = (state != IDLE);

    // Register the context bus once; the FSM only looks at these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_val_r <= 1'b0;
            ctx_in_r  <= 8'h00;
        end else begin
            ctx_val_r <= ctx_val;
            ctx_in_r  <= ctx_in;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state; bytes arriving outside IDLE/WR_DATA are dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (ctx_val_r) state_nxt = ctx_in_r[7] ? WR_DATA : RD_DELAY;
            WR_DATA:   if (ctx_val_r && last_byte) state_nxt = WR_COMMIT;
            WR_COMMIT: state_nxt = IDLE;
            RD_DELAY:  state_nxt = RD_DATA;
            RD_DATA:   if (last_byte) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Address latch, byte counter, write assembly and read serialisation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr          <= 7'h00;
            cnt           <= '0;
            wr_word       <= '0;
            rd_shift      <= '0;
            ctx_out_r     <= 8'h00;
            ctx_out_val_r <= 1'b0;
        end else begin
            ctx_out_r     <= 8'h00;
            ctx_out_val_r <= 1'b0;
            case (state)
                IDLE: if (ctx_val_r) addr <= ctx_in_r[6:0];
                WR_DATA: if (ctx_val_r) begin
                    wr_word <= {wr_word[DATA_W-9:0], ctx_in_r};
                    cnt     <= cnt + CW'(1);
                end
                WR_COMMIT: cnt <= '0;
                RD_DELAY:  rd_shift <= rd_word;
                RD_DATA: begin
                    ctx_out_r     <= rd_shift[DATA_W-1 -: 8];
                    ctx_out_val_r <= 1'b1;
                    rd_shift      <= {rd_shift[DATA_W-9:0], 8'h00};
                    cnt           <= last_byte ? '0 : cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end

    // Read mux: unmapped addresses return the repeating DE AD BE EF fill.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < BYTES; i++) begin
            rd_word[DATA_W-1-8*i -: 8] = FILL[31-8*(i%4) -: 8];
        end
        if (addr == CTRL_ADDR) rd_word = DATA_W'(ctrl);
        for (int n = 0; n < NUM_CH; n++) begin
            if (addr == 7'(36 + 4*n)) rd_word = sor_flat[n*DATA_W +: DATA_W];
        end
    end

    // CTRL keeps only 16 bits; upper write bits are discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                          ctrl <= 16'h0000;
        else if (state == WR_COMMIT && addr == CTRL_ADDR)    ctrl <= wr_word[15:0];
    end

    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        localparam logic [6:0] SOR_ADDR = 7'(36 + 4*n);
        logic              wr_hit;
        logic              rc_hit;
        logic [DATA_W-1:0] res;
        logic [DATA_W-1:0] acc;
        logic [DATA_W-1:0] sor;

        assign wr_hit = (state == WR_COMMIT) && (addr == SOR_ADDR);
        assign rc_hit = (state == RD_DELAY) && (addr == SOR_ADDR);
        assign res    = alu_result[n*DATA_W +: DATA_W];
`ifdef ALU_CSR_SAT_EN
        logic [DATA_W:0] sum;
        assign sum = {1'b0, sor} + {1'b0, res};
        assign acc = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        assign acc = sor + res;
`endif
        assign sor_flat[n*DATA_W +: DATA_W] = sor;

        // Accumulator: bus write beats read-clear beats accumulation.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)                      sor <= '0;
            else if (wr_hit)                 sor <= wr_word;
            else if (rc_hit && alu_ready[n]) sor <= res;
            else if (rc_hit)                 sor <= '0;
            else if (alu_ready[n])           sor <= acc;
        end
    end

    // Output stage: one more register after the read serialiser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctx_out     <= 8'h00;
            ctx_out_val <= 1'b0;
        end else begin
            ctx_out     <= ctx_out_r;
            ctx_out_val <= ctx_out_val_r;
        end
    end
endmodule

// File: tb/tb_alu_csr_bank.sv
// tb_alu_csr_bank: directed plus randomized bench for alu_csr_bank with a
// transaction-level model of CTRL and the SOR accumulators.
module tb_alu_csr_bank;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 4;
    localparam int BYTES  = DATA_W / 8;
    localparam int RW     = NUM_CH * DATA_W;

    logic              clk;
    logic              rst_n;
    logic              ctx_val;
    logic [7:0]        ctx_in;
    logic [NUM_CH-1:0] alu_ready;
    logic [RW-1:0]     alu_result;
    logic [7:0]        ctx_out;
    logic              ctx_out_val;
    logic [7:0]        k_val;
    logic [7:0]        c_val;
    logic              busy;

    alu_csr_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst_n(rst_n), .ctx_val(ctx_val), .ctx_in(ctx_in),
        .alu_ready(alu_ready), .alu_result(alu_result), .ctx_out(ctx_out),
        .ctx_out_val(ctx_out_val), .k_val(k_val), .c_val(c_val), .busy(busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [39:0]       exp_q[$];    // {edge index, expected byte}
    logic [15:0]       m_ctrl;
    logic [DATA_W-1:0] m_sor [NUM_CH];
    logic              pend_wr;
    int                pend_wr_edge;
    logic [6:0]        pend_wr_addr;
    logic [DATA_W-1:0] pend_wr_data;
    logic              pend_rd;
    int                pend_rd_edge;
    logic [6:0]        pend_rd_addr;
    logic [DATA_W-1:0] last_rd;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sor_idx(input logic [6:0] a);
        int d;
        d = int'(a) - 36;
        if (d >= 0 && d % 4 == 0 && d / 4 < NUM_CH) return d / 4;
        return -1;
    endfunction

    function automatic logic [DATA_W-1:0] model_read(input logic [6:0] a);
        logic [31:0]       fill;
        logic [DATA_W-1:0] v;
        fill = 32'hDEADBEEF;
        if (a == 7'h20) return DATA_W'(m_ctrl);
        if (sor_idx(a) >= 0) return m_sor[sor_idx(a)];
        for (int i = 0; i < BYTES; i++) v[DATA_W-1-8*i -: 8] = fill[31-8*(i%4) -: 8];
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] model_add(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef ALU_CSR_SAT_EN
        longint s;
        s = longint'(a) + longint'(b);
        if (s > longint'({DATA_W{1'b1}})) return {DATA_W{1'b1}};
        return DATA_W'(s);
`else
        return a + b;
`endif
    endfunction

    // Apply everything that happened at the edge just passed.
    task automatic model_edge(input logic [NUM_CH-1:0] rdy, input logic [RW-1:0] res);
        int e;
        int rc;
        int wc;
        logic [DATA_W-1:0] snap;
        e  = edge_cnt;
        rc = -1;
        wc = -1;
        if (pend_rd && pend_rd_edge == e) begin
            snap = model_read(pend_rd_addr);
            for (int k = 0; k < BYTES; k++) exp_q.push_back({32'(e + 2 + k), snap[DATA_W-1-8*k -: 8]});
            rc = sor_idx(pend_rd_addr);
            pend_rd = 1'b0;
        end
        if (pend_wr && pend_wr_edge == e) begin
            wc = sor_idx(pend_wr_addr);
            if (pend_wr_addr == 7'h20) m_ctrl = pend_wr_data[15:0];
            pend_wr = 1'b0;
        end
        for (int n = 0; n < NUM_CH; n++) begin
            if (n == wc)          m_sor[n] = pend_wr_data;
            else if (n == rc)     m_sor[n] = rdy[n] ? res[n*DATA_W +: DATA_W] : '0;
            else if (rdy[n])      m_sor[n] = model_add(m_sor[n], res[n*DATA_W +: DATA_W]);
        end
    endtask

    task automatic model_clear();
        m_ctrl  = 16'h0000;
        for (int n = 0; n < NUM_CH; n++) m_sor[n] = '0;
        exp_q.delete();
        pend_wr = 1'b0;
        pend_rd = 1'b0;
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [39:0] e;
        while (exp_q.size() > 0 && int'(exp_q[0][39:8]) < edge_cnt) begin
            e = exp_q.pop_front();
            chk("rd_byte_missed", 0, {32'h0, e[7:0]});
        end
        if (exp_q.size() > 0 && int'(exp_q[0][39:8]) == edge_cnt) begin
            e = exp_q.pop_front();
            chk("ctx_out_val", {63'h0, ctx_out_val}, 64'h1);
            chk("ctx_out", {56'h0, ctx_out}, {56'h0, e[7:0]});
            last_rd = {last_rd[DATA_W-9:0], ctx_out};
        end else begin
            chk("ctx_out_quiet", {55'h0, ctx_out_val, ctx_out}, 64'h0);
        end
        chk("k_c_val", {48'h0, c_val, k_val}, {48'h0, m_ctrl});
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic v, input logic [7:0] b, input logic [NUM_CH-1:0] rdy, input logic [RW-1:0] res);
        ctx_val    = v;
        ctx_in     = b;
        alu_ready  = rdy;
        alu_result = res;
        @(posedge clk);
        #1;
        model_edge(rdy, res);
        ctx_val   = 1'b0;
        alu_ready = '0;
    endtask

    function automatic logic [RW-1:0] one_res(input int ch, input logic [DATA_W-1:0] v);
        logic [RW-1:0] r;
        r = '0;
        r[ch*DATA_W +: DATA_W] = v;
        return r;
    endfunction

    task automatic tstep(input logic v, input logic [7:0] b, input bit rnd);
        logic [NUM_CH-1:0] rdy;
        logic [RW-1:0]     res;
        rdy = '0;
        res = '0;
        if (rnd) begin
            for (int n = 0; n < NUM_CH; n++) begin
                rdy[n] = ($urandom_range(0, 9) < 3);
                res[n*DATA_W +: DATA_W] = ($urandom_range(0, 3) == 0) ? DATA_W'($urandom_range(0, 255))
                                                                      : DATA_W'($urandom);
            end
        end
        step(v, b, rdy, res);
    endtask

    task automatic gap(input int n, input bit rnd);
        repeat (n) tstep(1'b0, 8'($urandom), rnd);
    endtask

    task automatic wr(input logic [6:0] a, input logic [DATA_W-1:0] d, input logic [BYTES-1:0] stalls, input bit rnd);
        tstep(1'b1, {1'b1, a}, rnd);
        for (int k = 0; k < BYTES; k++) begin
            tstep(1'b1, d[DATA_W-1-8*k -: 8], rnd);
            if (k == BYTES - 1) begin
                pend_wr      = 1'b1;
                pend_wr_edge = edge_cnt + 2;
                pend_wr_addr = a;
                pend_wr_data = d;
            end else if (stalls[k]) begin
                tstep(1'b0, 8'($urandom), rnd);
            end
        end
        tstep(rnd ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom), rnd);
    endtask

    task automatic rd(input logic [6:0] a, input bit rnd, input int s_idx,
                      input logic [NUM_CH-1:0] s_rdy, input logic [RW-1:0] s_res);
        tstep(1'b1, {1'b0, a}, rnd);
        pend_rd      = 1'b1;
        pend_rd_edge = edge_cnt + 2;
        pend_rd_addr = a;
        for (int i = 0; i < BYTES + 1; i++) begin
            if (i == s_idx) step(1'b0, 8'h00, s_rdy, s_res);
            else            tstep(rnd ? 1'($urandom_range(0, 1)) : 1'b0, 8'($urandom), rnd);
        end
    endtask

    task automatic rd_chk(input string name, input logic [6:0] a, input logic [DATA_W-1:0] lit);
        rd(a, 1'b0, -1, '0, '0);
        gap(3, 1'b0);
        chk(name, 64'(last_rd), 64'(lit));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_outputs", {38'h0, busy, ctx_out_val, ctx_out, k_val, c_val}, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [6:0]        a;
        logic [DATA_W-1:0] d;
        rst_n      = 1'b0;
        ctx_val    = 1'b0;
        ctx_in     = 8'h00;
        alu_ready  = '0;
        alu_result = '0;
        last_rd    = '0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_state", {38'h0, busy, ctx_out_val, ctx_out, k_val, c_val}, 64'h0);

        // CTRL write with a stall between bytes 2 and 3, then read back.
        wr(7'h20, 32'h0000_5AC3, 4'b0010, 1'b0);
        gap(1, 1'b0);
        chk("ctrl_k_val", {56'h0, k_val}, 64'hC3);
        chk("ctrl_c_val", {56'h0, c_val}, 64'h5A);
        rd_chk("ctrl_read", 7'h20, 32'h0000_5AC3);

        // Channel 1 accumulation and read-clear; others untouched.
        step(1'b0, 8'h00, 4'b0010, one_res(1, 32'h10));
        step(1'b0, 8'h00, 4'b0010, one_res(1, 32'h20));
        rd_chk("sor1_sum", 7'h28, 32'h30);
        rd_chk("sor1_cleared", 7'h28, 32'h0);
        rd_chk("sor2_untouched", 7'h2C, 32'h0);
        rd_chk("sor3_untouched", 7'h30, 32'h0);

        // Channel 0 preload near the top, then overflow.
        wr(7'h24, 32'hFFFF_FFF0, '0, 1'b0);
        gap(1, 1'b0);
        step(1'b0, 8'h00, 4'b0001, one_res(0, 32'h20));
`ifdef ALU_CSR_SAT_EN
        rd_chk("sor0_overflow", 7'h24, 32'hFFFF_FFFF);
`else
        rd_chk("sor0_overflow", 7'h24, 32'h0000_0010);
`endif

        // Strobe on channel 2 in the same cycle as its read-clear.
        rd(7'h2C, 1'b0, 1, 4'b0100, one_res(2, 32'h7));
        gap(3, 1'b0);
        chk("sor2_prior", 64'(last_rd), 64'h0);
        rd_chk("sor2_after_clear", 7'h2C, 32'h7);

        // Unmapped read pattern and ignored unmapped write.
        rd_chk("unmapped_read", 7'h40, 32'hDEAD_BEEF);
        wr(7'h40, 32'h1357_9BDF, '0, 1'b0);
        gap(1, 1'b0);
        rd_chk("ctrl_after_unmapped_wr", 7'h20, 32'h0000_5AC3);
        rd_chk("sor1_after_unmapped_wr", 7'h28, 32'h0);

        // Reset in the middle of a CTRL write.
        tstep(1'b1, 8'hA0, 1'b0);
        tstep(1'b1, 8'h00, 1'b0);
        tstep(1'b1, 8'h00, 1'b0);
        chk("busy_mid_write", {63'h0, busy}, 64'h1);
        do_reset();
        gap(4, 1'b0);
        chk("post_reset_idle", {47'h0, busy, k_val, c_val}, 64'h0);
        wr(7'h20, 32'h0000_1234, '0, 1'b0);
        gap(1, 1'b0);
        chk("ctrl_after_reset", {48'h0, c_val, k_val}, 64'h1234);

        // Randomized traffic against the model.
        repeat (250) begin
            case ($urandom_range(0, 9))
                0, 1:    a = 7'h20;
                2, 3, 4, 5, 6, 7: a = 7'(36 + 4 * $urandom_range(0, NUM_CH - 1));
                default: a = 7'($urandom);
            endcase
            d = ($urandom_range(0, 3) == 0) ? ~DATA_W'($urandom_range(0, 255)) : DATA_W'($urandom);
            if ($urandom_range(0, 9) < 4) wr(a, d, BYTES'($urandom), 1'b1);
            else                          rd(a, 1'b1, -1, '0, '0);
            gap($urandom_range(0, 2), 1'b1);
        end
        gap(8, 1'b0);
        chk("drain", 64'(exp_q.size()), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_csr_bank.md
Name: alu_csr_bank

Overview:
- Parametrised CSR block for the ALU subsystem; next generation of the single-channel ALU CSR.
- Decodes a byte-serial context bus (header byte, then data bytes) into register reads and writes.
- Holds the control register (k_val/c_val) and NUM_CH per-channel sum-of-results (SOR) accumulators, each with read-clear.
- Sits between the context bus master and NUM_CH ALU result ports.

Parameters:
- DATA_W, 32, register/result width in bits; multiple of 8, min 16.
- NUM_CH, 4, number of ALU channels/SOR registers; 1..16.
- BYTES, DATA_W/8, bytes per data phase (derived; not overridden).

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ctx_val  input  1  context byte valid
- ctx_in  input  8  context byte; header: bit7=1 write / 0 read, [6:0]=address
- alu_ready  input  NUM_CH  per-channel result strobe
- alu_result  input  NUM_CH*DATA_W  channel n occupies bits [n*DATA_W +: DATA_W]
- ctx_out  output  8  read data byte
- ctx_out_val  output  1  ctx_out holds a valid read byte
- k_val  output  8  CTRL[7:0]
- c_val  output  8  CTRL[15:8]
- busy  output  1  FSM not in IDLE

Behaviour:
- Reset (async): all outputs 0; CTRL, all SOR, and input/output registers 0; FSM to IDLE; byte counter 0. Reset mid-transaction aborts it; no partial write is committed.
- ctx_val/ctx_in are registered once (ctx_val_r, ctx_in_r). The FSM acts only on the registered copies.
- Address map: 0x20 CTRL (bits >=16 read 0, write ignored); 0x24+4n SOR[n] for n<NUM_CH. All other addresses are unmapped.
- FSM states:
  - IDLE: on ctx_val_r, latch addr=ctx_in_r[6:0]; go to WR_DATA if bit7=1, else RD_DELAY.
  - WR_DATA: each cycle with ctx_val_r=1, shift ctx_in_r into the write word, MSB byte first, and increment the counter. On the BYTES-th byte, go to WR_COMMIT. Cycles with ctx_val_r=0 are stalls; state is held.
  - WR_COMMIT: one cycle; write the word to the addressed register (unmapped: ignored); clear the counter; go to IDLE.
  - RD_DELAY: one cycle; snapshot the addressed register into the read shift register (unmapped: repeating bytes DE,AD,BE,EF, MSB first). If the target is SOR[n], clear it at this same edge (read-clear). Go to RD_DATA.
  - RD_DATA: BYTES cycles; ctx_out_r <= next snapshot byte, MSB first; after the last byte, go to IDLE.
- ctx_val_r in RD_DELAY/RD_DATA/WR_COMMIT is ignored and the byte dropped.
- ctx_out/ctx_out_val are registered once more after ctx_out_r. Read latency: header sampled at edge N; byte k on ctx_out with ctx_out_val=1 after edge N+4+k, k=0..BYTES-1. ctx_out=0 and ctx_out_val=0 otherwise.
- Write latency: k_val/c_val update at the edge after WR_COMMIT is entered, i.e. 2 edges after the last data byte is sampled into ctx_in_r.
- SOR[n] update priority, highest first, per edge:
  - WR_COMMIT to SOR[n]: load the write data; the alu_result that cycle is discarded.
  - read-clear and alu_ready[n] together: SOR[n] <= alu_result[n].
  - read-clear only: SOR[n] <= 0.
  - alu_ready[n] only: SOR[n] <= SOR[n]+alu_result[n], modulo 2^DATA_W (wrap).
- Channels update independently and concurrently.

Optional Feature:
- Macro ALU_CSR_SAT_EN.
  - Defined: accumulation saturates at all-ones (2^DATA_W-1) instead of wrapping. The read-clear and simultaneous-event rules are unchanged.
  - Undefined: wrap modulo 2^DATA_W.

Test Plan:
- DATA_W=32, NUM_CH=4. Write header 0xA0, bytes 00,00,5A,C3 with one ctx_val=0 stall between bytes 2 and 3 -> k_val=0xC3, c_val=0x5A. Then read header 0x20 -> ctx_out 00,00,5A,C3 at N+4..N+7 with ctx_out_val=1.
- ch1: alu_ready pulses with 0x10 then 0x20; read 0x28 -> 00,00,00,30; second read 0x28 -> 00,00,00,00 (read-clear). Other channels unchanged.
- SOR[0] preloaded by writing 0xFFFFFFF0 to 0x24, then alu_result 0x20 -> read 00,00,00,10. With ALU_CSR_SAT_EN -> FF,FF,FF,FF.
- ch2 alu_ready with 0x7 at the RD_DELAY edge of a read of 0x2C -> read returns the prior value; a subsequent read returns 00,00,00,07.
- Read unmapped 0x40 -> DE,AD,BE,EF. Write to 0x40 -> no register changes.
- rst_n low after 2 of 4 write bytes to 0x20 -> busy=0, all outputs 0, k_val/c_val remain 0. A following full write succeeds.
